// File: rtl/adder_arbiter.sv
// ============================================================================
//  Module      : adder_arbiter
//  Description : Round-robin scheduler sharing one registered 16-bit
//                hierarchical carry-lookahead adder among NREQ requesters.
//                Optional statistics (op_count, stall) under ADDER_ARB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module adder_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [15:0]          resp_sum,
    output logic [IDW-1:0]       resp_id,
`ifdef ADDER_ARB_STATS_EN
    output logic [15:0]          op_count,
    output logic                 stall,
`endif
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [15:0]     op_a_q, op_a_d;
    logic [15:0]     op_b_q, op_b_d;
    logic [15:0]     sum_q, sum_d;

    logic [NREQ-1:0] grant;
    logic            any_valid;
    logic [IDW-1:0]  win_id;
    logic [15:0]     win_a;
    logic [15:0]     win_b;

    // ------------------------------------------------------------------
    // Round-robin pick: first pass covers indices above the last winner,
    // second pass wraps to indices at or below it.
    // ------------------------------------------------------------------
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        win_id    = '0;
        win_a     = '0;
        win_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any_valid && req_valid[i] && (IDW'(i) > last_q)) begin
                any_valid = 1'b1;
                grant[i]  = 1'b1;
                win_id    = IDW'(i);
                win_a     = req_a[16*i +: 16];
                win_b     = req_b[16*i +: 16];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!any_valid && req_valid[i] && (IDW'(i) <= last_q)) begin
                any_valid = 1'b1;
                grant[i]  = 1'b1;
                win_id    = IDW'(i);
                win_a     = req_a[16*i +: 16];
                win_b     = req_b[16*i +: 16];
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared adder: 4-bit lookahead groups feeding a second-level group
    // lookahead. Carry-in is zero and the carry-out is never formed.
    // ------------------------------------------------------------------
    logic [14:0] add_g;
    logic [15:0] add_p;
    logic [15:0] add_c;
    logic [15:0] add_sum;
    logic [2:0]  grp_g;
    logic [2:1]  grp_p;
    logic [3:0]  grp_cin;

    assign add_g = op_a_q[14:0] & op_b_q[14:0];
    assign add_p = op_a_q ^ op_b_q;

    assign grp_cin[0] = 1'b0;
    assign grp_cin[1] = grp_g[0];
    assign grp_cin[2] = grp_g[1] | (grp_p[1] & grp_g[0]);
    assign grp_cin[3] = grp_g[2] | (grp_p[2] & grp_g[1])
                      | (grp_p[2] & grp_p[1] & grp_g[0]);

    for (genvar k = 0; k < 4; k++) begin : g_grp
        localparam int c_base = 4 * k;

        assign add_c[c_base]   = grp_cin[k];
        assign add_c[c_base+1] = add_g[c_base]
                               | (add_p[c_base] & grp_cin[k]);
        assign add_c[c_base+2] = add_g[c_base+1]
                               | (add_p[c_base+1] & add_g[c_base])
                               | (add_p[c_base+1] & add_p[c_base] & grp_cin[k]);
        assign add_c[c_base+3] = add_g[c_base+2]
                               | (add_p[c_base+2] & add_g[c_base+1])
                               | (add_p[c_base+2] & add_p[c_base+1] & add_g[c_base])
                               | (add_p[c_base+2] & add_p[c_base+1] & add_p[c_base]
                                  & grp_cin[k]);

        if (k < 3) begin : g_grp_gen
            assign grp_g[k] = add_g[c_base+3]
                            | (add_p[c_base+3] & add_g[c_base+2])
                            | (add_p[c_base+3] & add_p[c_base+2] & add_g[c_base+1])
                            | (add_p[c_base+3] & add_p[c_base+2] & add_p[c_base+1]
                               & add_g[c_base]);
            if (k > 0) begin : g_grp_prop
                assign grp_p[k] = &add_p[c_base+3:c_base];
            end
        end
    end

    assign add_sum = add_p ^ add_c;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        sum_d      = sum_q;
        req_ready  = '0;
        resp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = grant;
                if (any_valid) begin
                    op_a_d  = win_a;
                    op_b_d  = win_b;
                    id_d    = win_id;
                    last_d  = win_id;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                sum_d   = add_sum;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            last_q  <= IDW'(NREQ - 1);
            id_q    <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
        end
    end

    assign resp_sum = sum_q;
    assign resp_id  = id_q;
    assign busy     = (state_q != ST_IDLE);

`ifdef ADDER_ARB_STATS_EN
    logic [15:0] op_count_q, op_count_d;

    // Saturating count of completed response handshakes.
    always_comb begin
        op_count_d = op_count_q;
        if (resp_valid && resp_ready && (op_count_q != 16'hFFFF)) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
    assign stall    = (state_q == ST_RESP) && !resp_ready;
`else
    // Statistics hardware is not built in this configuration.
`endif

endmodule

`default_nettype wire
